// File: rtl/sinc_sample_buffer_if.sv
// Bus between the sinc3 sample buffer and its neighbours: the decimator word
// side (word_clk/data_in), the quasi-static offset, and the host read port
// with its status flags.
interface sinc_sample_buffer_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
);
  logic          word_clk;
  logic [15:0]   data_in;
  logic [15:0]   offset;
  logic          rd_en;
  logic          clr_ovf;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  // Driver side: decimator plus host controller.
  modport master (
    output word_clk, data_in, offset, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  // Buffer side.
  modport slave (
    input  word_clk, data_in, offset, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/sinc_sample_buffer.sv
// Output buffer behind the sinc3 decimator. Detects each new word on
// word_clk, captures it, subtracts a signed offset with saturation and
// queues the result in a DEPTH-entry FIFO drained by the host.
// Single clock domain (mclk1), synchronous active-high reset.
module sinc_sample_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 mclk1,
  input  logic                 reset,
  sinc_sample_buffer_if.slave  bus
);

  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  // Signed a - b, clamped to the 16-bit two's complement range.
  function automatic logic [15:0] sat_sub(input logic [15:0] a,
                                          input logic [15:0] b);
    logic [16:0] diff;
    logic [15:0] res;
    diff = {a[15], a} - {b[15], b};
    if (diff[16] != diff[15]) begin
      res = diff[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      res = diff[15:0];
    end
    return res;
  endfunction

  // word_clk edge detector
  logic wc_q;
  logic wc_qq;
  logic strobe;

  // pipeline stage 1
  logic [15:0] samp_q;
  logic        samp_v;
  logic [15:0] corr;

  // FIFO storage and bookkeeping
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          empty_q;
  logic          full_q;
  logic [15:0]   rd_data_q;
  logic          rd_valid_q;
  logic          overflow_q;

  logic wr_acc;
  logic rd_acc;
  logic drop;

  // Two-stage sampler of word_clk; preset high so a word_clk that is already
  // high when reset releases does not look like a fresh edge.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      wc_q  <= 1'b1;
      wc_qq <= 1'b1;
    end else begin
      wc_q  <= bus.word_clk;
      wc_qq <= wc_q;
    end
  end

  assign strobe = wc_q & ~wc_qq;

  // Stage 1: capture the decimator word on the detected rising edge.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      samp_q <= 16'h0000;
      samp_v <= 1'b0;
    end else if (strobe) begin
      samp_q <= bus.data_in;
      samp_v <= 1'b1;
    end else begin
      samp_v <= 1'b0;
    end
  end

  // Stage 2 is combinational; the corrected word is written into the FIFO.
  assign corr = sat_sub(samp_q, bus.offset);

  // Accept/read/drop decisions; a write while full needs a same-cycle read.
  always_comb begin
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    drop   = 1'b0;
    if (bus.rd_en && !empty_q) begin
      rd_acc = 1'b1;
    end else begin
      rd_acc = 1'b0;
    end
    if (samp_v) begin
      if (!full_q || bus.rd_en) begin
        wr_acc = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else begin
      wr_acc = 1'b0;
      drop   = 1'b0;
    end
  end

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // Pointers, occupancy and registered empty/full flags.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      wr_ptr  <= {AW{1'b0}};
      rd_ptr  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q <= count_nxt;
      empty_q <= (count_nxt == {(AW+1){1'b0}});
      full_q  <= (count_nxt == CNT_DEPTH);
    end
  end

  // Sample storage; contents survive reset, and a word in flight at reset is lost.
  always_ff @(posedge mclk1) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= corr;
    end
  end

  // Host read port: one-cycle valid pulse, data holds between reads.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      rd_data_q  <= 16'h0000;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_sinc_sample_buffer.sv
// Bench for sinc_sample_buffer: directed scenarios with literal expectations
// followed by randomized traffic, all cross-checked every cycle against a
// queue-based model of the buffer.
module tb_sinc_sample_buffer;
  localparam int DEPTH = 16;

  logic mclk1;
  logic reset;
  int   n_cmp;
  int   n_bad;

  sinc_sample_buffer_if #(.DEPTH(16), .AW(4)) bus();

  sinc_sample_buffer #(.DEPTH(16), .AW(4)) dut (
    .mclk1 (mclk1),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    mclk1 = 1'b0;
    forever #5 mclk1 = ~mclk1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] m_sat(input logic [15:0] d, input logic [15:0] o);
    int v;
    v = int'($signed(d)) - int'($signed(o));
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] q[$];
  logic        m_rv;
  logic [15:0] m_rd;
  logic        m_ovf;
  logic        last_wc;
  logic        rise_prev;
  logic        cap_v;
  logic [15:0] cap_val;
  logic        started;
  int          m_sz;
  logic        m_drop;

  initial started = 1'b0;

  always @(posedge mclk1) begin
    started = 1'b1;
    if (reset) begin
      q.delete();
      m_rv = 1'b0; m_rd = 16'h0000; m_ovf = 1'b0;
      last_wc = 1'b1; rise_prev = 1'b0; cap_v = 1'b0; cap_val = 16'h0000;
    end else begin
      m_sz   = q.size();
      m_rv   = 1'b0;
      m_drop = 1'b0;
      if (bus.rd_en && m_sz > 0) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (cap_v) begin
        if (m_sz < DEPTH || bus.rd_en) q.push_back(m_sat(cap_val, bus.offset));
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
      cap_v     = rise_prev;
      cap_val   = bus.data_in;
      rise_prev = bus.word_clk && !last_wc;
      last_wc   = bus.word_clk;
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge mclk1) begin
    if (started) begin
      chk("m_rd_valid", bus.rd_valid, m_rv);
      chk("m_rd_data",  bus.rd_data,  m_rd);
      chk("m_count",    bus.count,    q.size());
      chk("m_empty",    bus.empty,    q.size() == 0);
      chk("m_full",     bus.full,     q.size() == DEPTH);
      chk("m_overflow", bus.overflow, m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge mclk1);
  endtask

  // word_clk must be low on entry; returns after the word has been written.
  task automatic push_word(input logic [15:0] d);
    bus.data_in = d;
    tick(2);
    bus.word_clk = 1'b1;
    tick(2);
    bus.word_clk = 1'b0;
    tick(2);
  endtask

  task automatic read_one(input string nm, input logic [15:0] exp);
    bus.rd_en = 1'b1;
    tick(1);
    chk({nm, "_valid"}, bus.rd_valid, 1'b1);
    chk({nm, "_data"},  bus.rd_data,  exp);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.word_clk = 1'b1;
    bus.data_in  = 16'h0000;
    bus.offset   = 16'h0000;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;

    // model pinning
    chk("model_sat_hi", m_sat(16'h7FF0, 16'hFF00), 16'h7FFF);
    chk("model_sat_lo", m_sat(16'h8010, 16'h0100), 16'h8000);

    // reset release with word_clk high
    tick(3);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_rd_data", bus.rd_data, 16'h0000);
    reset = 1'b0;
    tick(5);
    chk("wc_hi_empty", bus.empty, 1'b1);
    chk("wc_hi_count", bus.count, 5'd0);
    bus.word_clk = 1'b0;
    tick(3);

    // basic capture and 2-cycle latency
    bus.data_in = 16'h1234;
    bus.offset  = 16'h0034;
    tick(2);
    bus.word_clk = 1'b1;
    tick(1);
    chk("lat_k_empty", bus.empty, 1'b1);
    tick(1);
    chk("lat_k1_empty", bus.empty, 1'b1);
    bus.word_clk = 1'b0;
    tick(1);
    chk("lat_k2_empty", bus.empty, 1'b0);
    chk("lat_k2_count", bus.count, 5'd1);
    read_one("basic", 16'h1200);
    tick(1);
    chk("basic_pulse_end", bus.rd_valid, 1'b0);

    // saturation
    bus.offset = 16'hFF00;
    push_word(16'h7FF0);
    read_one("sat_hi", 16'h7FFF);
    bus.offset = 16'h0100;
    push_word(16'h8010);
    read_one("sat_lo", 16'h8000);
    tick(1);

    // fill to full, then one dropped word
    bus.offset = 16'h0000;
    for (int i = 1; i <= 16; i++) push_word(16'(i * 16'h0101));
    chk("fill_full", bus.full, 1'b1);
    chk("fill_count", bus.count, 5'd16);
    chk("fill_no_ovf", bus.overflow, 1'b0);
    push_word(16'hEEEE);
    chk("drop_ovf", bus.overflow, 1'b1);
    chk("drop_count", bus.count, 5'd16);
    for (int i = 1; i <= 16; i++) read_one("drain", 16'(i * 16'h0101));
    tick(1);
    chk("drain_empty", bus.empty, 1'b1);

    // clr_ovf alone
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    chk("clr_alone", bus.overflow, 1'b0);

    // full with concurrent read
    for (int i = 1; i <= 16; i++) push_word(16'(16'hA000 + i));
    bus.data_in = 16'hBEEF;
    tick(2);
    bus.word_clk = 1'b1;
    tick(2);
    bus.word_clk = 1'b0;
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    chk("conc_valid", bus.rd_valid, 1'b1);
    chk("conc_data", bus.rd_data, 16'hA001);
    chk("conc_count", bus.count, 5'd16);
    chk("conc_ovf", bus.overflow, 1'b0);
    tick(2);

    // drop with clr_ovf in the same cycle
    bus.data_in = 16'hDEAD;
    tick(2);
    bus.word_clk = 1'b1;
    tick(2);
    bus.word_clk = 1'b0;
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    chk("set_wins", bus.overflow, 1'b1);
    chk("set_wins_count", bus.count, 5'd16);
    for (int i = 2; i <= 16; i++) read_one("drain2", 16'(16'hA000 + i));
    read_one("drain2_last", 16'hBEEF);

    // read while empty
    bus.rd_en = 1'b1;
    tick(3);
    bus.rd_en = 1'b0;
    chk("uf_valid", bus.rd_valid, 1'b0);
    chk("uf_count", bus.count, 5'd0);
    chk("uf_hold", bus.rd_data, 16'hBEEF);

    // randomized traffic
    fork
      begin
        for (int w = 0; w < 150; w++) begin
          bus.data_in = 16'($urandom);
          tick($urandom_range(2, 6));
          bus.word_clk = 1'b1;
          tick($urandom_range(2, 6));
          bus.word_clk = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 1500; c++) begin
          int p;
          p = (c < 500) ? 5 : ((c < 1000) ? 70 : 30);
          bus.rd_en   = ($urandom_range(0, 99) < p);
          bus.clr_ovf = ($urandom_range(0, 31) == 0);
          if ($urandom_range(0, 63) == 0) bus.offset = 16'($urandom);
          tick(1);
        end
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
      end
    join
    bus.word_clk = 1'b0;
    tick(3);

    // reset with a word in flight
    bus.rd_en = 1'b1;
    tick(20);
    bus.rd_en = 1'b0;
    bus.data_in = 16'h5555;
    tick(2);
    bus.word_clk = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    bus.word_clk = 1'b0;
    tick(5);
    chk("inflight_empty", bus.empty, 1'b1);
    chk("inflight_count", bus.count, 5'd0);
    chk("inflight_ovf", bus.overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
